ber_checker: RTL
================

# ber_checker

Bit-error-rate checker at the receive end of the PRBS9 + BPSK + RC link. It consumes baud-rate samples of the RC filter output and recovers bits by sign decision. It searches for the latency between the transmitted PRBS9 stream and the received stream, then counts received bits and bit errors. It fills the BER slot of the top level and drives the "BER = 0" indicator LED.

## Interface
Parameters:
- NB_DATA, 8: width of the signed filter sample.
- NB_COUNT, 64: width of the bit and error counters.
- MAX_DELAY, 511: number of candidate delays, 0..MAX_DELAY-1; also the depth of the reference history.
- SYNC_LEN, 511: compares per candidate delay during search.

Ports:
- clock, input, 1: system clock; the only clock.
- i_reset, input, 1: reset, asynchronous, active-high.
- i_enable, input, 1: RX enable (switch 1).
- i_data, input, NB_DATA: signed filter sample.
- i_valid, input, 1: RX baud strobe; one cycle wide, already phase-selected.
- i_ref_bit, input, 1: transmitted PRBS9 bit.
- i_ref_valid, input, 1: TX baud strobe.
- o_bit_count, output, NB_COUNT: bits compared while LOCKED.
- o_err_count, output, NB_COUNT: errors counted while LOCKED.
- o_delay, output, clog2(MAX_DELAY): selected delay.
- o_locked, output, 1: high in LOCKED.
- o_ber_zero, output, 1: o_locked AND o_err_count == 0.

## Operation
- Decision: rx_bit = ~i_data[NB_DATA-1]. A sample ≥ 0 decides 1; a negative sample decides 0.
- Reference history: a MAX_DELAY-bit shift register, updated on i_ref_valid with hist[0] <= i_ref_bit and hist[k] <= hist[k-1].
  - Compares use the pre-edge history value.
  - Candidate d compares rx_bit against hist[d].
  - The history runs regardless of i_enable and state.
- IDLE: entered on reset or when i_enable is low. Compares are ignored and all outputs hold.
- IDLE → SEARCH: on the first cycle with i_enable high. On entry:
  - counters, o_delay and o_locked are cleared;
  - cand = 0 and best_err = all-ones.
- SEARCH: each i_valid counts one compare into win_cnt and adds one to win_err on mismatch. On the i_valid that completes SYNC_LEN compares:
  - the window result includes that compare;
  - if win_err < best_err (strict), best_err <= win_err and best_delay <= cand, so the lowest delay wins ties;
  - win_cnt and win_err clear;
  - if cand == MAX_DELAY-1, go to LOCKED with o_delay <= best_delay (or cand, if cand won on this edge); otherwise cand increments.
- LOCKED: each i_valid increments o_bit_count and, on mismatch against hist[o_delay], increments o_err_count.
  - Both counters saturate at all-ones, independently.
  - The delay never changes in LOCKED.
- Any state → IDLE when i_enable goes low. Counters hold. Re-enabling restarts the search from cand = 0 with counters cleared.
- Simultaneous i_valid and i_ref_valid: the compare uses the old history, and the history shifts on the same edge.

## Timing
- Reset values: all outputs 0, state IDLE, history all zeros.
- All outputs are registered.
- Counters reflect a strobe one cycle after it.
- o_locked and o_delay update on the edge of the final window's last strobe.
- Search length: MAX_DELAY × SYNC_LEN RX strobes.
- An i_valid in the same cycle as the LOCKED transition is consumed by SEARCH. The first LOCKED compare is the next i_valid.
- Asserting i_reset mid-operation immediately forces reset values.

## Configuration
- BER_EARLY_LOCK_EN
  - Defined: SEARCH ends at the first window with win_err == 0, locking to that cand. If no such window exists, the exhaustive rule applies.
  - Undefined: the exhaustive minimum search described above.

## Test plan
All scenarios use SYNC_LEN=16 and MAX_DELAY=64 unless stated. The RX and TX strobes are simultaneous, one every 4 cycles.

- Reset: pulse i_reset mid-stream → all outputs 0, state IDLE; the next enable restarts the search from cand 0.
- Loopback: rx sign bit at strobe k = ref bit k-37, error-free → o_locked rises after 1024 RX strobes, o_delay = 36, o_ber_zero = 1 while bits accumulate.
- Error injection: after lock, flip every 100th decision over 1000 strobes → o_bit_count = 1000, o_err_count = 10, o_ber_zero = 0.
- Saturation: NB_COUNT=4, 20 error-free compares after lock → o_bit_count = 15 and holds.
- Enable toggle: drop i_enable at cand 10 → outputs hold. Re-raise it → counters 0, the search restarts from 0 and locks to 36 again.
- Macro: BER_EARLY_LOCK_EN defined, loopback at delay 36 → lock after 37 × 16 = 592 strobes, o_delay = 36.

Source files
------------

// File: rtl/ber_checker.sv
// ber_checker
//
// Receive-side bit-error-rate checker for the PRBS9 + BPSK + RC link.
// A sign decision turns each baud-rate filter sample into a bit. The block
// first searches for the latency between the transmitted PRBS9 stream and
// the received bits. It then counts received bits and bit errors at that
// latency.
//
// Optional feature macro: BER_EARLY_LOCK_EN
//   defined   - the search stops at the first candidate window with zero errors
//   undefined - exhaustive minimum-error search over all candidate delays
//
// Ports
//   clock        system clock, the only clock
//   i_reset      asynchronous active-high reset
//   i_enable     RX enable; low forces IDLE with all outputs held
//   i_data       signed filter sample (NB_DATA bits)
//   i_valid      RX baud strobe, one cycle wide
//   i_ref_bit    transmitted PRBS9 bit
//   i_ref_valid  TX baud strobe; shifts the reference history
//   o_bit_count  bits compared while LOCKED (saturating)
//   o_err_count  errors counted while LOCKED (saturating)
//   o_delay      selected delay
//   o_locked     high once the search has finished
//   o_ber_zero   o_locked and no errors counted
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | disabled or just reset; compares ignored, outputs hold
// SEARCH | scoring candidate delay cand over SYNC_LEN-compare windows
// LOCKED | counting bits/errors against hist[o_delay]

module ber_checker #(
  parameter int NB_DATA   = 8,
  parameter int NB_COUNT  = 64,
  parameter int MAX_DELAY = 511,
  parameter int SYNC_LEN  = 511
) (
  input  logic                         clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic [NB_DATA-1:0]           i_data,
  input  logic                         i_valid,
  input  logic                         i_ref_bit,
  input  logic                         i_ref_valid,
  output logic [NB_COUNT-1:0]          o_bit_count,
  output logic [NB_COUNT-1:0]          o_err_count,
  output logic [$clog2(MAX_DELAY)-1:0] o_delay,
  output logic                         o_locked,
  output logic                         o_ber_zero
);

  localparam int NB_DELAY = $clog2(MAX_DELAY);
  localparam int NB_WIN   = $clog2(SYNC_LEN + 1);

  localparam logic [NB_DELAY-1:0] LAST_CAND = NB_DELAY'(MAX_DELAY - 1);
  localparam logic [NB_WIN-1:0]   WIN_LEN   = NB_WIN'(SYNC_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [MAX_DELAY-1:0] hist;
  logic [NB_DELAY-1:0]  cand;
  logic [NB_DELAY-1:0]  best_delay;
  logic [NB_WIN-1:0]    best_err;
  logic [NB_WIN-1:0]    win_cnt;
  logic [NB_WIN-1:0]    win_err;

  logic                 rx_bit;
  logic [NB_DELAY-1:0]  sel_delay;
  logic                 mismatch;
  logic [NB_WIN-1:0]    win_cnt_inc;
  logic [NB_WIN-1:0]    win_err_inc;
  logic                 win_done;
  logic                 better;
  logic                 early_hit;
  logic                 search_end;
  logic [NB_DELAY-1:0]  lock_delay;

  logic                 start;
  logic                 search_cmp;
  logic                 lock_cmp;

  // Only the sign bit carries the decision.
  logic                 data_unused;
  assign data_unused = ^i_data[NB_DATA-2:0];

  assign rx_bit = ~i_data[NB_DATA-1];

  // Reference history runs independently of the FSM. Compares read the
  // pre-edge value, so a simultaneous TX strobe does not disturb them.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      hist <= '0;
    end else if (i_ref_valid) begin
      hist <= {hist[MAX_DELAY-2:0], i_ref_bit};
    end
  end

  // One comparator is shared: SEARCH scores cand, LOCKED uses o_delay.
  assign sel_delay = (state == LOCKED) ? o_delay : cand;
  assign mismatch  = rx_bit ^ hist[sel_delay];

  assign win_cnt_inc = win_cnt + NB_WIN'(1);
  assign win_err_inc = win_err + NB_WIN'(mismatch);
  assign win_done    = (win_cnt_inc == WIN_LEN);
  // Strict compare keeps the earliest (lowest) delay on ties.
  assign better      = (win_err_inc < best_err);

`ifdef BER_EARLY_LOCK_EN
  assign early_hit = (win_err_inc == '0);
`else
  assign early_hit = 1'b0;
`endif

  assign search_end = search_cmp && win_done && ((cand == LAST_CAND) || early_hit);

  // A window that wins on the final edge has not yet reached best_delay.
  assign lock_delay = (early_hit || better) ? cand : best_delay;

  // State register
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_enable) begin
          state_nx = SEARCH;
        end
      end
      SEARCH: begin
        if (!i_enable) begin
          state_nx = IDLE;
        end else if (search_end) begin
          state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (!i_enable) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control decode; a strobe on the cycle enable drops is ignored.
  always_comb begin
    start      = 1'b0;
    search_cmp = 1'b0;
    lock_cmp   = 1'b0;
    case (state)
      IDLE:    start      = i_enable;
      SEARCH:  search_cmp = i_enable && i_valid;
      LOCKED:  lock_cmp   = i_enable && i_valid;
      default: start      = 1'b0;
    endcase
  end

  // Search and counting datapath; every output is a register here.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      cand        <= '0;
      best_delay  <= '0;
      best_err    <= '1;
      win_cnt     <= '0;
      win_err     <= '0;
      o_bit_count <= '0;
      o_err_count <= '0;
      o_delay     <= '0;
      o_locked    <= 1'b0;
      o_ber_zero  <= 1'b0;
    end else if (start) begin
      cand        <= '0;
      best_delay  <= '0;
      best_err    <= '1;
      win_cnt     <= '0;
      win_err     <= '0;
      o_bit_count <= '0;
      o_err_count <= '0;
      o_delay     <= '0;
      o_locked    <= 1'b0;
      o_ber_zero  <= 1'b0;
    end else if (search_cmp) begin
      if (win_done) begin
        win_cnt <= '0;
        win_err <= '0;
        if (better) begin
          best_err   <= win_err_inc;
          best_delay <= cand;
        end
        if (search_end) begin
          o_delay    <= lock_delay;
          o_locked   <= 1'b1;
          o_ber_zero <= (o_err_count == '0);
        end else begin
          cand <= cand + NB_DELAY'(1);
        end
      end else begin
        win_cnt <= win_cnt_inc;
        win_err <= win_err_inc;
      end
    end else if (lock_cmp) begin
      if (!(&o_bit_count)) begin
        o_bit_count <= o_bit_count + NB_COUNT'(1);
      end
      if (mismatch && !(&o_err_count)) begin
        o_err_count <= o_err_count + NB_COUNT'(1);
      end
      o_ber_zero <= !mismatch && (o_err_count == '0);
    end
  end

endmodule
